flag_branch_unit: RTL
=====================

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ex_valid, input, 1, ALU result valid this cycle.
REQ-004 SHALL have port ex_op, input, 4, ALU opcode of the valid op.
REQ-005 SHALL have port alu_flags, input, 3, ALU flags {N,Z,V} (bit2 = N, bit1 = Z, bit0 = V).
REQ-006 SHALL have port br_valid, input, 1, a conditional branch requests resolution; held high while stall = 1.
REQ-007 SHALL have port br_cond, input, 3, branch condition code.
REQ-008 SHALL have port flush, input, 1, kills any pending branch.
REQ-009 SHALL have port flags_q, output, 3, architectural flag register {N,Z,V}.
REQ-010 SHALL have port stall, output, 1, upstream must hold the branch this cycle.
REQ-011 SHALL have port br_done, output, 1, registered one-cycle pulse: branch resolved.
REQ-012 SHALL have port br_taken, output, 1, registered outcome; meaningful only when br_done = 1.

Function
REQ-013 SHALL derive a write mask from ex_op when ex_valid = 1: ops 0000/0001 write N, Z and V; ops 0010/0100/0101/0110 write Z only; all other ops write nothing.
REQ-014 SHALL update only the masked bits of flags_q from alu_flags at the clock edge; unmasked bits hold their value.
REQ-015 SHALL evaluate br_cond as follows: 000 NE = !Z; 001 EQ = Z; 010 GT = !Z & !N; 011 LT = N; 100 GE = Z | (!Z & !N); 101 LE = N | Z; 110 OV = V; 111 always taken.
REQ-016 SHALL implement states IDLE and HOLD.
REQ-017 In IDLE with br_valid = 1 and no flag hazard, SHALL evaluate against flags_q and register br_done = 1 and br_taken = result at the next edge (latency 1).
REQ-018 A flag hazard SHALL be defined as br_valid = 1 in the same cycle as ex_valid = 1 with a non-zero write mask.
REQ-019 On a hazard in IDLE, SHALL assert stall combinationally, move to HOLD, and produce no br_done.
REQ-020 In HOLD, SHALL deassert stall, evaluate against the updated flags_q, pulse br_done at the next edge, and return to IDLE (total latency 2).
REQ-021 In HOLD, a new ex_valid flag write SHALL NOT re-stall; evaluation SHALL use flags_q as registered.
REQ-022 flush = 1 SHALL force the state to IDLE and suppress br_done and stall in that cycle; flags_q updates SHALL proceed unaffected.
REQ-023 flush and br_valid asserted together SHALL leave no pending state.
REQ-024 br_done SHALL never be high on two consecutive cycles for the same branch.

Reset
REQ-025 rst_n low SHALL asynchronously set flags_q = 000, br_done = 0, br_taken = 0 and state = IDLE; stall SHALL be 0 while in reset.
REQ-026 Reset asserted in HOLD SHALL drop the pending branch with no br_done after release.

Configuration
REQ-027 With FLAG_FWD_EN defined, SHALL treat a hazard as no stall: evaluate against the merged flags (masked alu_flags over flags_q) in the same cycle, with latency 1; HOLD is unreachable.
REQ-028 Without FLAG_FWD_EN, SHALL use the HOLD behaviour of REQ-019/REQ-020.

Structure
REQ-029 A shared package SHALL hold the flag bit indices, ALU opcode constants, condition-code constants and the state enumeration.
REQ-030 Condition evaluation SHALL be a combinational sub-module branch_cond_eval (inputs: flags[2:0] and cond[2:0]; output: taken).

Verification
REQ-031 Bench SHALL check flag masking: flags_q = 101, then ex_op = 0010 with alu_flags = 010 -> flags_q = 111 (N and V unchanged).
REQ-032 Bench SHALL check the non-hazard path: flags_q = 010, br_valid with cond = 001 and no ex_valid -> br_done = 1 and br_taken = 1 one cycle later.
REQ-033 Bench SHALL check the hazard path without FLAG_FWD_EN: ex_op = 0001 with alu_flags = 100 while br_valid with cond = 011 -> stall = 1 for 1 cycle, then br_done with br_taken = 1 two cycles after the request.
REQ-034 Bench SHALL check the hazard path with FLAG_FWD_EN: same stimulus as REQ-033 -> stall stays 0, br_done with br_taken = 1 one cycle after the request.
REQ-035 Bench SHALL check flush in HOLD: assert flush -> no br_done follows and the state returns to IDLE.
REQ-036 Bench SHALL check reset in HOLD: pulse rst_n low -> flags_q = 000, br_done = 0, and stall = 0 after release.

Source files
------------

// File: rtl/flag_branch_unit_pkg.sv
// rtl/flag_branch_unit_pkg.sv - shared flag indices, opcodes, condition codes and states for flag_branch_unit
package flag_branch_unit_pkg;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_TST = 4'b0110;

    localparam logic [2:0] MASK_NZV  = 3'b111;
    localparam logic [2:0] MASK_Z    = 3'b010;
    localparam logic [2:0] MASK_NONE = 3'b000;

    localparam logic [2:0] COND_NE = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_GT = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_LE = 3'b101;
    localparam logic [2:0] COND_OV = 3'b110;
    localparam logic [2:0] COND_AL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic [2:0] flag_write_mask(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB:                 return MASK_NZV;
            OP_AND, OP_OR, OP_XOR, OP_TST:  return MASK_Z;
            default:                        return MASK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational condition-code evaluation against {N,Z,V}
module branch_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic n;
    logic z;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE: taken = !z;
            COND_EQ: taken = z;
            COND_GT: taken = !z && !n;
            COND_LT: taken = n;
            COND_GE: taken = z || (!z && !n);
            COND_LE: taken = n || z;
            COND_OV: taken = v;
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - flag register with branch resolution; FLAG_FWD_EN forwards ALU flags instead of stalling
module flag_branch_unit
    import flag_branch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid,
    input  logic [3:0] ex_op,
    input  logic [2:0] alu_flags,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    input  logic       flush,
    output logic [2:0] flags_q,
    output logic       stall,
    output logic       br_done,
    output logic       br_taken
);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] wr_mask;
    logic [2:0] flags_merged;
    logic [2:0] eval_flags;
    logic [2:0] eval_cond;
    logic [2:0] hold_cond;
    logic [2:0] hold_cond_nxt;
    logic       hazard;
    logic       eval_taken;
    logic       done_nxt;
    logic       stall_raw;

    assign wr_mask      = ex_valid ? flag_write_mask(ex_op) : MASK_NONE;
    assign flags_merged = (flags_q & ~wr_mask) | (alu_flags & wr_mask);
    assign hazard       = br_valid && (wr_mask != MASK_NONE);

    branch_cond_eval u_cond_eval (
        .flags (eval_flags),
        .cond  (eval_cond),
        .taken (eval_taken)
    );

    always_comb begin
        state_nxt     = state;
        stall_raw     = 1'b0;
        done_nxt      = 1'b0;
        hold_cond_nxt = hold_cond;
        eval_flags    = flags_q;
        eval_cond     = br_cond;
        case (state)
            ST_IDLE: begin
                if (!flush && br_valid) begin
`ifdef FLAG_FWD_EN
                    eval_flags = hazard ? flags_merged : flags_q;
                    done_nxt   = 1'b1;
`else
                    if (hazard) begin
                        stall_raw     = 1'b1;
                        state_nxt     = ST_HOLD;
                        hold_cond_nxt = br_cond;
                    end else begin
                        done_nxt = 1'b1;
                    end
`endif
                end
            end
            ST_HOLD: begin
                // flags_q now holds the write that caused the stall
                state_nxt = ST_IDLE;
                eval_cond = hold_cond;
                done_nxt  = !flush;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign stall = stall_raw && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flags_q   <= 3'b000;
            br_done   <= 1'b0;
            br_taken  <= 1'b0;
            hold_cond <= COND_NE;
        end else begin
            state     <= state_nxt;
            flags_q   <= flags_merged;
            br_done   <= done_nxt;
            hold_cond <= hold_cond_nxt;
            if (done_nxt) begin
                br_taken <= eval_taken;
            end
        end
    end

endmodule
